// File: rtl/cl_axil_pkg.sv
// Shared types for the CL AXI4-Lite initiator: FSM states, response codes and
// the latched command record.
package cl_axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WB,
        RA,
        RD,
        RSP,
        DRAIN
    } axil_mst_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } axil_cmd_t;

endpackage

// File: rtl/cl_axil_timeout_cnt.sv
// Response-wait timer: cleared while idle, counts while enabled and flags the
// last allowed cycle so the initiator can give up on a silent slave.
module cl_axil_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count;

    // Holds at LAST so an unconsumed expire never wraps into a fresh window.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && !clear && (count == LAST);

endmodule

// File: rtl/cl_axil_master.sv
// Single-outstanding AXI4-Lite initiator: accepts one command, runs AW/W/B or
// AR/R on the master port and returns exactly one response per command.
module cl_axil_master
    import cl_axil_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk_main_a0,
    input  logic             rst_main,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_wr,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,
    input  logic [3:0]       cmd_wstrb,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_wr,
    output logic [31:0]      rsp_rdata,
    output logic [1:0]       rsp_resp,
    output logic             rsp_timeout,
    output logic [CNT_W-1:0] err_count,

    output logic             m_awvalid,
    input  logic             m_awready,
    output logic [31:0]      m_awaddr,
    output logic             m_wvalid,
    input  logic             m_wready,
    output logic [31:0]      m_wdata,
    output logic [3:0]       m_wstrb,
    input  logic             m_bvalid,
    output logic             m_bready,
    input  logic [1:0]       m_bresp,
    output logic             m_arvalid,
    input  logic             m_arready,
    output logic [31:0]      m_araddr,
    input  logic             m_rvalid,
    output logic             m_rready,
    input  logic [31:0]      m_rdata,
    input  logic [1:0]       m_rresp
);

    axil_mst_state_t state_q, state_nxt;
    axil_cmd_t       cmd_q, cmd_nxt;

    logic             cmd_ready_q, cmd_ready_nxt;
    logic             awvalid_q, awvalid_nxt;
    logic             wvalid_q, wvalid_nxt;
    logic             arvalid_q, arvalid_nxt;
    logic             bready_q, bready_nxt;
    logic             rready_q, rready_nxt;
    logic             aw_done_q, aw_done_nxt;
    logic             w_done_q, w_done_nxt;
    logic             late_pend_q, late_pend_nxt;
    logic             rsp_valid_q, rsp_valid_nxt;
    logic [31:0]      rsp_rdata_q, rsp_rdata_nxt;
    logic [1:0]       rsp_resp_q, rsp_resp_nxt;
    logic             rsp_timeout_q, rsp_timeout_nxt;
    logic [CNT_W-1:0] err_count_q, err_count_nxt;

    logic timer_run;
    logic timer_expire;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic late_beat;

    assign timer_run = (state_q == WB) || (state_q == RD);

    cl_axil_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (clk_main_a0),
        .rst    (rst_main),
        .clear  (!timer_run),
        .enable (timer_run),
        .expire (timer_expire)
    );

    assign aw_hs     = awvalid_q && m_awready;
    assign w_hs      = wvalid_q && m_wready;
    assign b_hs      = bready_q && m_bvalid;
    assign ar_hs     = arvalid_q && m_arready;
    assign r_hs      = rready_q && m_rvalid;
    assign late_beat = late_pend_q && (b_hs || r_hs);

    // Next-state and next-output decode; every register defaults to holding.
    always_comb begin
        state_nxt       = state_q;
        cmd_nxt         = cmd_q;
        awvalid_nxt     = awvalid_q;
        wvalid_nxt      = wvalid_q;
        arvalid_nxt     = arvalid_q;
        bready_nxt      = bready_q;
        rready_nxt      = rready_q;
        aw_done_nxt     = aw_done_q;
        w_done_nxt      = w_done_q;
        late_pend_nxt   = late_pend_q;
        rsp_valid_nxt   = rsp_valid_q;
        rsp_rdata_nxt   = rsp_rdata_q;
        rsp_resp_nxt    = rsp_resp_q;
        rsp_timeout_nxt = rsp_timeout_q;
        err_count_nxt   = err_count_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_nxt.wr    = cmd_wr;
                    cmd_nxt.addr  = cmd_addr;
                    cmd_nxt.wdata = cmd_wdata;
                    cmd_nxt.wstrb = cmd_wstrb;
                    if (cmd_wr) begin
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        aw_done_nxt = 1'b0;
                        w_done_nxt  = 1'b0;
                        state_nxt   = WR;
                    end else begin
                        arvalid_nxt = 1'b1;
                        state_nxt   = RA;
                    end
                end
            end

            WR: begin
                if (aw_hs) begin
                    awvalid_nxt = 1'b0;
                    aw_done_nxt = 1'b1;
                end
                if (w_hs) begin
                    wvalid_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_nxt = 1'b1;
                    state_nxt  = WB;
                end
            end

            WB: begin
                if (b_hs) begin
                    bready_nxt      = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_resp_nxt    = m_bresp;
                    rsp_rdata_nxt   = '0;
                    rsp_timeout_nxt = 1'b0;
                    state_nxt       = RSP;
                end else if (timer_expire) begin
                    rsp_valid_nxt   = 1'b1;
                    rsp_resp_nxt    = RESP_SLVERR;
                    rsp_rdata_nxt   = '0;
                    rsp_timeout_nxt = 1'b1;
                    late_pend_nxt   = 1'b1;
                    state_nxt       = RSP;
                end
            end

            RA: begin
                if (ar_hs) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = RD;
                end
            end

            RD: begin
                if (r_hs) begin
                    rready_nxt      = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_resp_nxt    = m_rresp;
                    rsp_rdata_nxt   = m_rdata;
                    rsp_timeout_nxt = 1'b0;
                    state_nxt       = RSP;
                end else if (timer_expire) begin
                    rsp_valid_nxt   = 1'b1;
                    rsp_resp_nxt    = RESP_SLVERR;
                    rsp_rdata_nxt   = '0;
                    rsp_timeout_nxt = 1'b1;
                    late_pend_nxt   = 1'b1;
                    state_nxt       = RSP;
                end
            end

            RSP: begin
                // A late beat after a timeout is swallowed here without a response.
                if (late_beat) begin
                    late_pend_nxt = 1'b0;
                    bready_nxt    = 1'b0;
                    rready_nxt    = 1'b0;
                end
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    if ((rsp_resp_q != RESP_OKAY) && (err_count_q != '1)) begin
                        err_count_nxt = err_count_q + 1'b1;
                    end
                    state_nxt = (late_pend_q && !late_beat) ? DRAIN : IDLE;
                end
            end

            DRAIN: begin
                if (late_beat) begin
                    late_pend_nxt = 1'b0;
                    bready_nxt    = 1'b0;
                    rready_nxt    = 1'b0;
                    state_nxt     = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        cmd_ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            cmd_ready_q   <= 1'b1;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            late_pend_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_nxt;
            cmd_q         <= cmd_nxt;
            cmd_ready_q   <= cmd_ready_nxt;
            awvalid_q     <= awvalid_nxt;
            wvalid_q      <= wvalid_nxt;
            arvalid_q     <= arvalid_nxt;
            bready_q      <= bready_nxt;
            rready_q      <= rready_nxt;
            aw_done_q     <= aw_done_nxt;
            w_done_q      <= w_done_nxt;
            late_pend_q   <= late_pend_nxt;
            rsp_valid_q   <= rsp_valid_nxt;
            rsp_rdata_q   <= rsp_rdata_nxt;
            rsp_resp_q    <= rsp_resp_nxt;
            rsp_timeout_q <= rsp_timeout_nxt;
            err_count_q   <= err_count_nxt;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_wr      = cmd_q.wr;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;
    assign err_count   = err_count_q;

    assign m_awvalid = awvalid_q;
    assign m_awaddr  = cmd_q.addr;
    assign m_wvalid  = wvalid_q;
    assign m_wdata   = cmd_q.wdata;
    assign m_wstrb   = cmd_q.wstrb;
    assign m_bready  = bready_q;
    assign m_arvalid = arvalid_q;
    assign m_araddr  = cmd_q.addr;
    assign m_rready  = rready_q;

endmodule
